// File: rtl/button_conditioner.sv
// Per-button 2-FF synchroniser, debounce FSM and press/release strobe generator.
// Optional auto-repeat of btn_press while held is built when BTN_REPEAT_EN is defined.

module button_channel #(
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rls
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          s1, s2;
    logic          level_nxt, press_nxt, rls_nxt;
    logic          held_entry;
    logic          rpt_fire;

    // Unsupported configuration; nothing is elaborated for it.
    if (DB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        level_nxt  = level;
        press_nxt  = 1'b0;
        rls_nxt    = 1'b0;
        held_entry = 1'b0;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_nxt = DB_PRESS;
                    cnt_nxt   = CW'(1);
                end
            end
            DB_PRESS: begin
                if (!s2) begin
                    state_nxt = IDLE;
                end else if (cnt == CW'(DB_CYCLES)) begin
                    state_nxt  = HELD;
                    press_nxt  = 1'b1;
                    level_nxt  = 1'b1;
                    held_entry = 1'b1;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!s2) begin
                    state_nxt = DB_RELEASE;
                    cnt_nxt   = CW'(1);
                end
            end
            DB_RELEASE: begin
                if (s2) begin
                    state_nxt = HELD;
                end else if (cnt == CW'(DB_CYCLES)) begin
                    state_nxt = IDLE;
                    rls_nxt   = 1'b1;
                    level_nxt = 1'b0;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt | rpt_fire;
            rls   <= rls_nxt;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt, rpt_nxt;
    logic          armed, armed_nxt;

    // armed selects the inter-repeat period once the initial delay has elapsed
    always_comb begin
        rpt_nxt   = rpt;
        armed_nxt = armed;
        rpt_fire  = 1'b0;
        if (held_entry) begin
            rpt_nxt   = '0;
            armed_nxt = 1'b0;
        end else if (state == HELD && s2) begin
            if (rpt == (armed ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
                rpt_fire  = 1'b1;
                rpt_nxt   = '0;
                armed_nxt = 1'b1;
            end else begin
                rpt_nxt = rpt + 1'b1;
            end
        end else if (state_nxt == IDLE) begin
            rpt_nxt   = '0;
            armed_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt   <= '0;
            armed <= 1'b0;
        end else begin
            rpt   <= rpt_nxt;
            armed <= armed_nxt;
        end
    end
`else
    logic unused_held_entry;
    assign unused_held_entry = held_entry;
    assign rpt_fire          = 1'b0;
`endif

endmodule

module button_conditioner #(
    parameter int NUM_BTN       = 4,
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rls  (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_button_conditioner;
    localparam int DB = 4, RD = 20, RP = 8;
`ifdef BTN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_raw = 4'b0;
    logic [3:0] btn_level, btn_press, btn_release;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int pcnt [4] = '{0, 0, 0, 0};
    int rcnt [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN(4), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // Pulse tallies, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            pcnt[i] += int'(btn_press[i]);
            rcnt[i] += int'(btn_release[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int  base;
        bit  exp_p;

        // reset state
        run(2);
        chk("rst_level",   32'(btn_level),   'h0);
        chk("rst_press",   32'(btn_press),   'h0);
        chk("rst_release", 32'(btn_release), 'h0);
        reset = 1'b1;
        run(3);

        // 1: clean press on right, 30 cycles
        btn_raw[1] = 1'b1;
        run(6);
        chk("t1_press_e6", 32'(btn_press), 'h0);
        chk("t1_level_e6", 32'(btn_level), 'h0);
        run(1);
        chk("t1_press_e7", 32'(btn_press), 'h2);
        chk("t1_level_e7", 32'(btn_level), 'h2);
        run(1);
        chk("t1_press_e8", 32'(btn_press), 'h0);
        run(22);
        btn_raw[1] = 1'b0;
        run(6);
        chk("t1_rel_e6",   32'(btn_release), 'h0);
        chk("t1_lvl_r6",   32'(btn_level),   'h2);
        run(1);
        chk("t1_rel_e7",   32'(btn_release), 'h2);
        chk("t1_lvl_r7",   32'(btn_level),   'h0);
        run(1);
        chk("t1_rel_e8",   32'(btn_release), 'h0);
        chk("t1_press_cnt", 32'(pcnt[1]), REP ? 2 : 1);
        chk("t1_other_press", 32'(pcnt[0] + pcnt[2] + pcnt[3]), 'h0);
        chk("t1_rel_cnt",  32'(rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3]), 'h1);

        // 2: bounce on left, 3 cycles
        btn_raw[0] = 1'b1;
        run(3);
        btn_raw[0] = 1'b0;
        run(12);
        chk("t2_press_cnt", 32'(pcnt[0]), 'h0);
        chk("t2_rel_cnt",   32'(rcnt[0]), 'h0);
        chk("t2_level",     32'(btn_level), 'h0);

        // 3: 2-cycle glitch while right is held
        base = rcnt[1];
        btn_raw[1] = 1'b1;
        run(10);
        chk("t3_level_held", 32'(btn_level), 'h2);
        btn_raw[1] = 1'b0;
        run(2);
        btn_raw[1] = 1'b1;
        run(5);
        chk("t3_level_glitch", 32'(btn_level), 'h2);
        chk("t3_no_release",   32'(rcnt[1] - base), 'h0);
        btn_raw[1] = 1'b0;
        run(10);
        chk("t3_level_end", 32'(btn_level), 'h0);
        chk("t3_release",   32'(rcnt[1] - base), 'h1);

        // 4: up and down together
        btn_raw[3:2] = 2'b11;
        run(6);
        chk("t4_press_e6", 32'(btn_press), 'h0);
        run(1);
        chk("t4_press_e7", 32'(btn_press), 'hC);
        chk("t4_level_e7", 32'(btn_level), 'hC);
        run(1);
        chk("t4_press_e8", 32'(btn_press), 'h0);
        run(2);
        btn_raw[3:2] = 2'b00;
        run(10);
        chk("t4_level_end", 32'(btn_level), 'h0);

        // 5: reset while left is mid-debounce, down held through reset
        btn_raw[3] = 1'b1;
        run(8);
        chk("t5_pre_level", 32'(btn_level), 'h8);
        btn_raw[0] = 1'b1;
        run(4);
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_level",   32'(btn_level),   'h0);
        chk("t5_rst_press",   32'(btn_press),   'h0);
        chk("t5_rst_release", 32'(btn_release), 'h0);
        run(2);
        reset = 1'b1;
        run(6);
        chk("t5_press_e6", 32'(btn_press), 'h0);
        run(1);
        chk("t5_press_e7", 32'(btn_press), 'h9);
        chk("t5_level_e7", 32'(btn_level), 'h9);
        run(1);
        chk("t5_press_e8", 32'(btn_press), 'h0);
        btn_raw = 4'b0;
        run(10);
        chk("t5_level_end", 32'(btn_level), 'h0);

        // 6: hold up for 60 cycles, then release
        btn_raw[2] = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            run(1);
            exp_p = (e == 7) || (REP && e >= 27 && e <= 61 && (e - 27) % 8 == 0);
            chk($sformatf("t6_press_e%0d", e), 32'(btn_press[2]), 32'(exp_p));
            chk($sformatf("t6_rel_e%0d", e),   32'(btn_release[2]), 32'(e == 67));
            if (e == 60) btn_raw[2] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
